// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with sign fix-up and a start/done handshake.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start, flush    request (accepted in IDLE only), pipeline abort
//   funct3          M-extension op select (sampled on accept)
//   op_a, op_b      rs1 / rs2 operands (sampled on accept)
//   busy            high in CALC and FIX
//   done            one-cycle pulse in DONE; result valid
//   result          final value, held until the next accept
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int RW    = XLEN + 1;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     res_q, res_d;

    // Operand decode on the request side
    logic            accept;
    logic            a_signed, b_signed;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            b_zero, ovf, special;
    logic [XLEN-1:0] spec_val;

    assign accept   = start & (state_q == S_IDLE) & ~flush;
    assign a_signed = (funct3 == F_MULH) | (funct3 == F_MULHSU) |
                      (funct3 == F_DIV)  | (funct3 == F_REM);
    assign b_signed = (funct3 == F_MULH) | (funct3 == F_DIV) |
                      (funct3 == F_REM);
    assign neg_a    = a_signed & op_a[XLEN-1];
    assign neg_b    = b_signed & op_b[XLEN-1];
    assign mag_a    = neg_a ? -op_a : op_a;
    assign mag_b    = neg_b ? -op_b : op_b;

    assign b_zero  = (op_b == '0);
    assign ovf     = ((funct3 == F_DIV) | (funct3 == F_REM)) &
                     (op_a == {1'b1, {(XLEN-1){1'b0}}}) &
                     (op_b == '1);
    assign special = funct3[2] & (b_zero | ovf);

    // funct3[1] separates REM/REMU from DIV/DIVU
    always_comb begin
        spec_val = '0;
        if (b_zero)
            spec_val = funct3[1] ? op_a : '1;
        else
            spec_val = funct3[1] ? '0 : op_a;
    end

    // One iteration of each datapath
    logic [XLEN:0]   mul_sum;
    logic [XLEN+1:0] div_sh;
    logic            div_ge;

    assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                     {1'b0, (prod_q[0] ? mcand_q : {XLEN{1'b0}})};
    assign div_sh  = {rem_q, quo_q[XLEN-1]};
    assign div_ge  = (div_sh >= {2'b00, mcand_q});

    // Sign fix-up and output selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    assign prod_fix = (sa_q ^ sb_q) ? -prod_q : prod_q;
    assign quo_fix  = (sa_q ^ sb_q) ? -quo_q : quo_q;
    assign rem_fix  = sa_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        fix_val = '0;
        unique case (f3_q)
            F_MUL:                      fix_val = prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              fix_val = quo_fix;
            F_REM, F_REMU:              fix_val = rem_fix;
            default:                    fix_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d  = funct3;
                    sa_d  = neg_a;
                    sb_d  = neg_b;
                    cnt_d = '0;
                    // mcand holds the multiplicand or the divisor
                    mcand_d = funct3[2] ? mag_b : mag_a;
                    prod_d  = {{XLEN{1'b0}}, mag_b};
                    quo_d   = mag_a;
                    rem_d   = '0;
                    if (special) begin
                        res_d   = spec_val;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (f3_q[2]) begin
                        rem_d = div_ge ? RW'(div_sh - {2'b00, mcand_q})
                                       : div_sh[XLEN:0];
                        quo_d = {quo_q[XLEN-2:0], div_ge};
                    end else begin
                        prod_d = {mul_sum, prod_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = fix_val;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f3_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end

    assign busy   = (state_q == S_CALC) | (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = res_q;

endmodule
